// File: rtl/pong_pkg.sv
// Shared encodings and default timing constants for the pong match sequencer
// and the text overlay that decodes its state.
package pong_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SCORE_W  = 7;
  localparam int unsigned WINNER_W = 2;

  localparam int unsigned DEF_WIN_SCORE          = 11;
  localparam int unsigned DEF_SERVE_DELAY_FRAMES = 120;
  localparam int unsigned DEF_OVER_DELAY_FRAMES  = 180;
  localparam int unsigned DEF_CNT_W              = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_PAUSED     = 3'd4,
    ST_OVER       = 3'd5
  } state_e;

  localparam logic [WINNER_W-1:0] WIN_NONE  = 2'b00;
  localparam logic [WINNER_W-1:0] WIN_LEFT  = 2'b01;
  localparam logic [WINNER_W-1:0] WIN_RIGHT = 2'b10;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic [SCORE_W-1:0] lim);
    return (v >= lim) ? lim : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Frame-tick countdown: load has priority, decrements on tick while nonzero,
// holds while frozen; expired_c flags a zero count.
module frame_countdown #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             freeze,
  output logic             expired_c
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && !freeze && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: serve timing, scoring, pause/resume and end-of-match
// hold, driving the graphics freeze and serve strobe.
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE          = DEF_WIN_SCORE,
  parameter int unsigned SERVE_DELAY_FRAMES = DEF_SERVE_DELAY_FRAMES,
  parameter int unsigned OVER_DELAY_FRAMES  = DEF_OVER_DELAY_FRAMES,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                miss_l,
  input  logic                miss_r,
  output logic                gra_still,
  output logic                serve_pulse,
  output logic                serve_dir,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r,
  output logic [WINNER_W-1:0] winner,
  output logic [STATE_W-1:0]  state
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_VAL = CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [CNT_W-1:0]   OVER_VAL  = CNT_W'(OVER_DELAY_FRAMES);

  state_e               state_q, state_d;
  state_e               resume_q, resume_d;
  logic                 gra_still_q, gra_still_d;
  logic                 serve_pulse_q, serve_pulse_d;
  logic                 serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic [WINNER_W-1:0]  winner_q, winner_d;
  logic                 start_prev_q, pause_prev_q;
  logic                 start_edge_c, pause_edge_c;
  logic                 cnt_load_c, cnt_expired_c;
  logic [CNT_W-1:0]     cnt_load_val_c;

  assign start_edge_c = start_btn & ~start_prev_q;
  assign pause_edge_c = pause_btn & ~pause_prev_q;

  frame_countdown #(.CNT_W(CNT_W)) u_countdown (
    .clk       (clk),
    .rst       (reset),
    .load      (cnt_load_c),
    .load_val  (cnt_load_val_c),
    .tick      (frame_tick),
    .freeze    (state_q == ST_PAUSED),
    .expired_c (cnt_expired_c)
  );

  // Next-state and registered-output logic; the serve strobe lands in the first PLAY cycle.
  always_comb begin
    state_d        = state_q;
    resume_d       = resume_q;
    serve_pulse_d  = 1'b0;
    serve_dir_d    = serve_dir_q;
    score_l_d      = score_l_q;
    score_r_d      = score_r_q;
    winner_d       = winner_q;
    cnt_load_c     = 1'b0;
    cnt_load_val_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          cnt_load_c     = 1'b1;
          cnt_load_val_c = SERVE_VAL;
          state_d        = ST_SERVE_WAIT;
        end
      end
      ST_SERVE_WAIT: begin
        if (cnt_expired_c) begin
          serve_pulse_d = 1'b1;
          state_d       = ST_PLAY;
        end else if (pause_edge_c) begin
          resume_d = ST_SERVE_WAIT;
          state_d  = ST_PAUSED;
        end
      end
      ST_PLAY: begin
        if (miss_l && miss_r) begin
          serve_dir_d = ~serve_dir_q;
          state_d     = ST_POINT;
        end else if (miss_l) begin
          score_r_d   = sat_inc(score_r_q, WIN_VAL);
          serve_dir_d = 1'b0;
          state_d     = ST_POINT;
        end else if (miss_r) begin
          score_l_d   = sat_inc(score_l_q, WIN_VAL);
          serve_dir_d = 1'b1;
          state_d     = ST_POINT;
        end else if (pause_edge_c) begin
          resume_d = ST_PLAY;
          state_d  = ST_PAUSED;
        end
      end
      ST_POINT: begin
        cnt_load_c = 1'b1;
        if (score_l_q == WIN_VAL) begin
          winner_d       = WIN_LEFT;
          cnt_load_val_c = OVER_VAL;
          state_d        = ST_OVER;
        end else if (score_r_q == WIN_VAL) begin
          winner_d       = WIN_RIGHT;
          cnt_load_val_c = OVER_VAL;
          state_d        = ST_OVER;
        end else begin
          cnt_load_val_c = SERVE_VAL;
          state_d        = ST_SERVE_WAIT;
        end
      end
      ST_PAUSED: begin
        if (pause_edge_c) state_d = resume_q;
      end
      ST_OVER: begin
        if (cnt_expired_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Scores and winner clear on the same edge that enters IDLE.
    if (state_d == ST_IDLE) begin
      score_l_d = '0;
      score_r_d = '0;
      winner_d  = WIN_NONE;
    end
    gra_still_d = (state_d != ST_PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      resume_q      <= ST_SERVE_WAIT;
      gra_still_q   <= 1'b1;
      serve_pulse_q <= 1'b0;
      serve_dir_q   <= 1'b1;
      score_l_q     <= '0;
      score_r_q     <= '0;
      winner_q      <= WIN_NONE;
      start_prev_q  <= 1'b0;
      pause_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      resume_q      <= resume_d;
      gra_still_q   <= gra_still_d;
      serve_pulse_q <= serve_pulse_d;
      serve_dir_q   <= serve_dir_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      winner_q      <= winner_d;
      start_prev_q  <= start_btn;
      pause_prev_q  <= pause_btn;
    end
  end

  assign gra_still   = gra_still_q;
  assign serve_pulse = serve_pulse_q;
  assign serve_dir   = serve_dir_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
